// File: rtl/light_bar_sequencer.sv
// light_bar_sequencer: synchronizes and debounces the pushbutton and mode
// switch, generates the periodic timer tick, and steps a four-pattern FSM
// either on button presses (manual) or after a fixed number of ticks (auto).
// Outputs are registered: one-hot pattern enables, BCD pattern index, tick.
module light_bar_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 25000000,
    parameter int DWELL_TICKS     = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       switch,
    input  logic       iButton,
    output logic [0:3] enables,
    output logic [3:0] stateBCD,
    output logic       timer
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW_W = $clog2(DWELL_TICKS + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_TICKS - 1);

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    // Handshake note: there is no valid/ready traffic here; the only
    // internal event is press_q, a one-cycle pulse consumed unconditionally
    // by the FSM on the edge that follows the debounced falling level.

    logic            btn_s1_q, btn_s2_q;
    logic            sw_s1_q, sw_s2_q;
    logic            db_q, db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic            timer_q, timer_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [1:0]      state_q, state_d;
    logic [0:3]      enables_q, enables_d;
    logic [3:0]      bcd_q, bcd_d;
    logic            mode_change, auto_mode, expire, advance;

    // Two-flop synchronizers; the button idles high (released), switch low.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            btn_s1_q <= 1'b1;
            btn_s2_q <= 1'b1;
            sw_s1_q  <= 1'b0;
            sw_s2_q  <= 1'b0;
        end else begin
            btn_s1_q <= iButton;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= switch;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive
    // differing samples; any agreeing sample restarts the count.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (btn_s2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d     = btn_s2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        // Only a released-to-pressed transition is an event.
        press_d = db_q & ~db_d;
    end

    // Free-running prescaler; timer is high while the count sits at its top.
    always_comb begin
        if (tick_cnt_q == TK_LAST) tick_cnt_d = '0;
        else                       tick_cnt_d = tick_cnt_q + TK_W'(1);
        timer_d = (tick_cnt_d == TK_LAST);
    end

    // Pattern FSM and dwell counter. A press and a dwell expiry on the same
    // edge both request the same single advance.
    always_comb begin
        mode_change = sw_s1_q ^ sw_s2_q;
        auto_mode   = sw_s2_q;
        expire      = auto_mode & ~mode_change & timer_q & (dwell_q == DW_LAST);
        advance     = press_q | expire;

        state_d = state_q;
        if (advance) begin
            case (state_q)
                P0:      state_d = P1;
                P1:      state_d = P2;
                P2:      state_d = P3;
                default: state_d = P0;
            endcase
        end

        dwell_d = dwell_q;
        if (!auto_mode || mode_change || advance) dwell_d = '0;
        else if (timer_q)                         dwell_d = dwell_q + DW_W'(1);
    end

    // Output decode from the next state so outputs move on the same edge.
    always_comb begin
        enables_d = 4'b1000;
        case (state_d)
            P0:      enables_d = 4'b1000;
            P1:      enables_d = 4'b0100;
            P2:      enables_d = 4'b0010;
            default: enables_d = 4'b0001;
        endcase
        bcd_d = {2'b00, state_d};
    end

    // All remaining state: debouncer, prescaler, FSM, dwell and outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            db_q       <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            tick_cnt_q <= '0;
            timer_q    <= 1'b0;
            dwell_q    <= '0;
            state_q    <= P0;
            enables_q  <= 4'b1000;
            bcd_q      <= 4'd0;
        end else begin
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            tick_cnt_q <= tick_cnt_d;
            timer_q    <= timer_d;
            dwell_q    <= dwell_d;
            state_q    <= state_d;
            enables_q  <= enables_d;
            bcd_q      <= bcd_d;
        end
    end

    assign enables  = enables_q;
    assign stateBCD = bcd_q;
    assign timer    = timer_q;

endmodule

// File: tb/tb_light_bar_sequencer.sv
// Testbench for light_bar_sequencer: scenario tasks with inline checks
// against an edge-level behavioural reference model.
module tb_light_bar_sequencer;

    localparam int D = 4;
    localparam int T = 5;
    localparam int W = 3;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       switch_r = 1'b0;
    logic       btn = 1'b1;
    logic [0:3] enables;
    logic [3:0] stateBCD;
    logic       timer;

    always #5 clock = ~clock;

    light_bar_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .TICK_CYCLES(T),
        .DWELL_TICKS(W)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .switch(switch_r),
        .iButton(btn),
        .enables(enables),
        .stateBCD(stateBCD),
        .timer(timer)
    );

    int total = 0;
    int bad = 0;

    // ---------------- reference model ----------------
    int   m_n;        // non-reset edges since last reset
    int   m_state;    // active pattern 0..3
    int   m_dwell;    // ticks counted toward the next auto advance
    bit   m_db;       // debounced button level
    int   m_run;      // consecutive samples disagreeing with m_db
    bit   m_press;    // press event to be applied at the next edge
    bit   btn_hist[$];
    bit   sw_hist[$];
    logic [0:3] exp_en;
    logic [3:0] exp_bcd;
    logic       exp_timer;

    task automatic model_edge(input bit r, input bit s, input bit b);
        bit s2b, sw1, sw2, tick, chg, expire, adv, new_press;
        if (!r) begin
            m_n = 0; m_state = 0; m_dwell = 0; m_db = 1; m_run = 0; m_press = 0;
            btn_hist = '{1'b1, 1'b1};
            sw_hist  = '{1'b0, 1'b0};
        end else begin
            s2b  = btn_hist[0];
            sw2  = sw_hist[0];
            sw1  = sw_hist[1];
            tick = (m_n % T) == (T - 1);
            chg  = (sw1 != sw2);
            expire = sw2 && !chg && tick && (m_dwell == W - 1);
            adv  = m_press || expire;
            if (!sw2 || chg || adv) m_dwell = 0;
            else if (tick)          m_dwell = m_dwell + 1;
            if (adv) m_state = (m_state + 1) % 4;
            new_press = 0;
            if (s2b != m_db) begin
                m_run = m_run + 1;
                if (m_run == D) begin
                    m_db = s2b;
                    m_run = 0;
                    new_press = (s2b == 1'b0);
                end
            end else begin
                m_run = 0;
            end
            m_press = new_press;
            void'(btn_hist.pop_front());
            btn_hist.push_back(b);
            void'(sw_hist.pop_front());
            sw_hist.push_back(s);
            m_n = m_n + 1;
        end
        exp_en    = 4'b1000 >> m_state;
        exp_bcd   = 4'(m_state);
        exp_timer = ((m_n % T) == (T - 1));
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit s, input bit b);
        reset_n  = r;
        switch_r = s;
        btn      = b;
        @(posedge clock);
        model_edge(r, s, b);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            total++;
            if (enables !== 4'b1000 || stateBCD !== 4'd0 || timer !== 1'b0) begin
                bad++;
                $display("FAIL reset: en=%b bcd=%0d timer=%b required en=1000 bcd=0 timer=0",
                         enables, stateBCD, timer);
            end
        end
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 1'b1);
            total++;
            if (timer !== ((k % T) == (T - 1)) || enables !== exp_en || stateBCD !== exp_bcd) begin
                bad++;
                $display("FAIL reset_timer edge %0d: timer=%b en=%b bcd=%0d required timer=%b en=%b bcd=%0d",
                         k, timer, enables, stateBCD, ((k % T) == (T - 1)), exp_en, exp_bcd);
            end
        end
    endtask

    task automatic test_manual_press;
        step(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 1'b0, (k <= 12) ? 1'b0 : 1'b1);
            total++;
            if (enables !== exp_en || stateBCD !== exp_bcd || timer !== exp_timer) begin
                bad++;
                $display("FAIL manual_press edge %0d: en=%b bcd=%0d timer=%b required en=%b bcd=%0d timer=%b",
                         k, enables, stateBCD, timer, exp_en, exp_bcd, exp_timer);
            end
            if (k == 6 || k == 7 || k == 24) begin
                total++;
                if (stateBCD !== ((k >= 7) ? 4'd1 : 4'd0)) begin
                    bad++;
                    $display("FAIL manual_latency edge %0d: bcd=%0d required %0d",
                             k, stateBCD, (k >= 7) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_glitch;
        step(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 25; k++) begin
            step(1'b1, 1'b0, ((k <= 3) || (k >= 10 && k <= 11)) ? 1'b0 : 1'b1);
            total++;
            if (enables !== 4'b1000 || stateBCD !== 4'd0) begin
                bad++;
                $display("FAIL glitch edge %0d: en=%b bcd=%0d required en=1000 bcd=0",
                         k, enables, stateBCD);
            end
        end
    endtask

    task automatic test_four_presses;
        step(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 80; k++) begin
            step(1'b1, 1'b0, ((k - 1) % 20 < 8) ? 1'b0 : 1'b1);
            total++;
            if (enables !== exp_en || stateBCD !== exp_bcd || $countones(enables) !== 1) begin
                bad++;
                $display("FAIL four_presses edge %0d: en=%b bcd=%0d required en=%b bcd=%0d",
                         k, enables, stateBCD, exp_en, exp_bcd);
            end
            if (k % 20 == 10) begin
                total++;
                if (stateBCD !== 4'((k / 20 + 1) % 4)) begin
                    bad++;
                    $display("FAIL four_presses_seq edge %0d: bcd=%0d required %0d",
                             k, stateBCD, (k / 20 + 1) % 4);
                end
            end
        end
    endtask

    task automatic test_auto;
        step(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 95; k++) begin
            step(1'b1, 1'b1, (k >= 69 && k < 77) ? 1'b0 : 1'b1);
            total++;
            if (enables !== exp_en || stateBCD !== exp_bcd || timer !== exp_timer) begin
                bad++;
                $display("FAIL auto edge %0d: en=%b bcd=%0d timer=%b required en=%b bcd=%0d timer=%b",
                         k, enables, stateBCD, timer, exp_en, exp_bcd, exp_timer);
            end
            if (k <= 74) begin
                total++;
                if (stateBCD !== 4'((k / 15) % 4)) begin
                    bad++;
                    $display("FAIL auto_period edge %0d: bcd=%0d required %0d",
                             k, stateBCD, (k / 15) % 4);
                end
            end
            if (k == 75 || k == 89 || k == 90) begin
                total++;
                if (stateBCD !== ((k == 90) ? 4'd2 : 4'd1)) begin
                    bad++;
                    $display("FAIL auto_coincident edge %0d: bcd=%0d required %0d",
                             k, stateBCD, (k == 90) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press;
        step(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            step(1'b1, 1'b1, (k >= 32) ? 1'b0 : 1'b1);
        end
        total++;
        if (stateBCD !== 4'd2) begin
            bad++;
            $display("FAIL mid_press_setup: bcd=%0d required 2", stateBCD);
        end
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (enables !== 4'b1000 || stateBCD !== 4'd0 || timer !== 1'b0) begin
            bad++;
            $display("FAIL mid_press_reset: en=%b bcd=%0d timer=%b required en=1000 bcd=0 timer=0",
                     enables, stateBCD, timer);
        end
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'b0);
            total++;
            if (stateBCD !== ((k >= 7) ? 4'd1 : 4'd0) || enables !== exp_en) begin
                bad++;
                $display("FAIL mid_press_after edge %0d: bcd=%0d en=%b required bcd=%0d en=%b",
                         k, stateBCD, enables, (k >= 7) ? 1 : 0, exp_en);
            end
        end
    endtask

    task automatic test_random;
        bit s, b;
        int hold;
        s = 1'b0;
        b = 1'b1;
        hold = 0;
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            if (hold == 0) begin
                b = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) s = ~s;
                hold = $urandom_range(1, 10);
            end
            hold--;
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, s, b);
            total++;
            if (enables !== exp_en || stateBCD !== exp_bcd || timer !== exp_timer) begin
                bad++;
                $display("FAIL random edge %0d: en=%b bcd=%0d timer=%b required en=%b bcd=%0d timer=%b",
                         k, enables, stateBCD, timer, exp_en, exp_bcd, exp_timer);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_manual_press();
        test_glitch();
        test_four_presses();
        test_auto();
        test_reset_mid_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
